// File: rtl/dev_input_sw.sv
// Debounced switch bank feeding the device read bus.
// Commits a value only after it has held steady; tracks events and overruns.
module dev_input_sw #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             rd_ack,
  output logic [31:0]      dev_rd,
  output logic             irq
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       evcnt;
  logic             chg;
  logic             ovr;
  logic [0:0]       state;

  logic             at_end;
  logic             commit;
  logic [15:0]      stable_ext;

  // Commit fires when a steady candidate differs from the held value
  always_comb begin
    at_end = (state == COUNT) && (sync2 == cand) && (cnt == CNT_LAST);
    commit = at_end && (cand != stable);
  end

  // Two-flop synchronizer for the raw asynchronous switch levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: restart on any change, commit after the hold window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      evcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (sync2 != stable) begin
            cand  <= sync2;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt   <= '0;
            state <= IDLE;
            if (commit) begin
              stable <= cand;
              evcnt  <= evcnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags: a new event beats a concurrent acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg <= 1'b0;
      ovr <= 1'b0;
    end else if (commit) begin
      chg <= 1'b1;
      if (rd_ack) begin
        ovr <= 1'b0;
      end else if (chg) begin
        ovr <= 1'b1;
      end
    end else if (rd_ack) begin
      chg <= 1'b0;
      ovr <= 1'b0;
    end
  end

  // Read word is a pure decode of registered state
  always_comb begin
    stable_ext = '0;
    stable_ext[WIDTH-1:0] = stable;
    dev_rd = {chg, ovr, 6'b0, evcnt, stable_ext};
    irq    = chg;
  end

endmodule

// File: tb/tb_dev_input_sw.sv
// Directed bench for dev_input_sw with the default parameters.
// Checks reset, debounce latency, glitches, overrun, ack races and wrap.
module tb_dev_input_sw;

  logic        clk;
  logic        rst;
  logic [15:0] sw_in;
  logic        rd_ack;
  logic [31:0] dev_rd;
  logic        irq;

  int n_chk;
  int n_fail;

  dev_input_sw #(
    .WIDTH(16),
    .DB_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .rd_ack(rd_ack),
    .dev_rd(dev_rd),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    sw_in  = 16'h0000;
    rd_ack = 1'b0;
    tick(3);
    chk("reset_rd", dev_rd, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick(2);
    chk("idle_rd", dev_rd, 32'h0);

    sw_in = 16'h00A5;
    tick(6);
    chk("clean_e6", dev_rd, 32'h0000_0000);
    tick(1);
    chk("clean_e7", dev_rd, 32'h8001_00A5);
    chk("clean_irq", {31'b0, irq}, 32'h1);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("ack_rd", dev_rd, 32'h0001_00A5);
    chk("ack_irq", {31'b0, irq}, 32'h0);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("ack_idle", dev_rd, 32'h0001_00A5);

    sw_in = 16'h00A4;
    tick(2);
    sw_in = 16'h00A5;
    tick(20);
    chk("glitch2", dev_rd, 32'h0001_00A5);
    sw_in = 16'h00A4;
    tick(4);
    sw_in = 16'h00A5;
    tick(20);
    chk("glitch4", dev_rd, 32'h0001_00A5);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    sw_in = 16'h0003;
    tick(7);
    chk("ovr_first", dev_rd, 32'h8002_0003);
    sw_in = 16'h0007;
    tick(7);
    chk("ovr_second", dev_rd, 32'hC003_0007);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("ovr_ack", dev_rd, 32'h0003_0007);

    sw_in = 16'h000F;
    tick(7);
    chk("race_first", dev_rd, 32'h8004_000F);
    sw_in = 16'h001F;
    tick(6);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("race_commit", dev_rd, 32'h8005_001F);

    sw_in = 16'hFFFF;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rd", dev_rd, 32'h0);
    chk("async_irq", {31'b0, irq}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_e6", dev_rd, 32'h0);
    tick(1);
    chk("post_rst_e7", dev_rd, 32'h8001_FFFF);

    for (int i = 0; i < 255; i++) begin
      sw_in = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
      tick(7);
      chk("wrap_evcnt", {24'b0, dev_rd[23:16]}, 32'((i + 2) % 256));
    end
    chk("wrap_final", dev_rd, 32'hC000_0000);
    chk("wrap_irq", {31'b0, irq}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
